tbird_light_decoder: RTL

Receive-side checker for the Thunderbird tail-light sequencer. It samples the two 3-bit lamp buses (`l_lights`, `r_lights`) and reconstructs the sequencer state. It reports each completed left, right and hazard sequence, and flags any lamp pattern or transition the sequencer can never legally produce. It sits on the lamp-driver side of the design, on the bench monitor or the body-controller readback path, opposite the sequencer.

---
 rtl/tbird_pkg.sv | 53 +++++
 rtl/tbird_pattern_classify.sv | 30 +++
 rtl/tbird_light_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tbird_pkg.sv
// Shared Thunderbird tail-light types: sequencer state, lamp patterns, decoder error causes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tbird_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_R1   = 3'd4,
        ST_R2   = 3'd5,
        ST_R3   = 3'd6,
        ST_LR3  = 3'd7
    } t_tbird_lights_state;

    // Lamp patterns packed as {l_lights, r_lights}.
    localparam logic [5:0] PAT_IDLE = 6'b000_000;
    localparam logic [5:0] PAT_L1   = 6'b001_000;
    localparam logic [5:0] PAT_L2   = 6'b011_000;
    localparam logic [5:0] PAT_L3   = 6'b111_000;
    localparam logic [5:0] PAT_R1   = 6'b000_001;
    localparam logic [5:0] PAT_R2   = 6'b000_011;
    localparam logic [5:0] PAT_R3   = 6'b000_111;
    localparam logic [5:0] PAT_LR3  = 6'b111_111;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_ILL_PAT   = 2'b01,
        ERR_ILL_TRANS = 2'b10
    } t_tbird_dec_err;

    // True when the sequencer can step from cur to nxt in one cycle.
    // Only IDLE may repeat; every other state advances each cycle.
    function automatic logic legal_trans(input t_tbird_lights_state cur,
                                         input t_tbird_lights_state nxt);
        logic ok;
        ok = 1'b0;
        case (cur)
            ST_IDLE: ok = (nxt == ST_IDLE) || (nxt == ST_L1) || (nxt == ST_R1) || (nxt == ST_LR3);
            ST_L1:   ok = (nxt == ST_L2)   || (nxt == ST_LR3);
            ST_L2:   ok = (nxt == ST_L3)   || (nxt == ST_LR3);
            ST_L3:   ok = (nxt == ST_IDLE) || (nxt == ST_LR3);
            ST_R1:   ok = (nxt == ST_R2)   || (nxt == ST_LR3);
            ST_R2:   ok = (nxt == ST_R3)   || (nxt == ST_LR3);
            ST_R3:   ok = (nxt == ST_IDLE) || (nxt == ST_LR3);
            ST_LR3:  ok = (nxt == ST_IDLE);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tbird_pattern_classify.sv
// Maps the two lamp buses to a sequencer state, flagging patterns the sequencer never drives.
// Latency: combinational, zero cycles.
// Backpressure: none.
module tbird_pattern_classify
    import tbird_pkg::*;
(
    input  logic [2:0]          l_lights,
    input  logic [2:0]          r_lights,
    output t_tbird_lights_state state,
    output logic                illegal
);

    // Decode the packed lamp pattern; unknown patterns report IDLE plus illegal.
    always_comb begin
        state   = ST_IDLE;
        illegal = 1'b0;
        case ({l_lights, r_lights})
            PAT_IDLE: state = ST_IDLE;
            PAT_L1:   state = ST_L1;
            PAT_L2:   state = ST_L2;
            PAT_L3:   state = ST_L3;
            PAT_R1:   state = ST_R1;
            PAT_R2:   state = ST_R2;
            PAT_R3:   state = ST_R3;
            PAT_LR3:  state = ST_LR3;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tbird_light_decoder.sv
// Rebuilds the tail-light sequencer state from lamp buses; pulses/counts completed sequences, flags errors.
// Latency: one cycle from sampling edge to every output (all registered). Build option: TBIRD_DEC_COUNT_EN.
// Backpressure: none; accepts one pattern per cycle whenever sample_en is high.
module tbird_light_decoder
    import tbird_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             sample_en,
    input  logic [2:0]       l_lights,
    input  logic [2:0]       r_lights,
    input  logic             clr_err,
    output logic             left_done,
    output logic             right_done,
    output logic             haz_done,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] haz_cnt
);

    t_tbird_lights_state obs_state;
    logic                obs_illegal;
    t_tbird_lights_state state_q, state_d;
    logic                left_d, right_d, haz_d;
    logic                err_set;
    t_tbird_dec_err      err_cause;
    logic                err_d;
    t_tbird_dec_err      err_code_q, err_code_d;

    tbird_pattern_classify u_classify (
        .l_lights (l_lights),
        .r_lights (r_lights),
        .state    (obs_state),
        .illegal  (obs_illegal)
    );

    // Next decoder state, completion pulses and error detection for this sample.
    always_comb begin
        state_d   = state_q;
        left_d    = 1'b0;
        right_d   = 1'b0;
        haz_d     = 1'b0;
        err_set   = 1'b0;
        err_cause = ERR_NONE;
        if (sample_en) begin
            if (obs_illegal) begin
                state_d   = ST_IDLE;
                err_set   = 1'b1;
                err_cause = ERR_ILL_PAT;
            end else if (!legal_trans(state_q, obs_state)) begin
                // Resync to what the lamps show so later sequences still decode.
                state_d   = obs_state;
                err_set   = 1'b1;
                err_cause = ERR_ILL_TRANS;
            end else begin
                state_d = obs_state;
                if (obs_state == ST_IDLE) begin
                    left_d  = (state_q == ST_L3);
                    right_d = (state_q == ST_R3);
                    haz_d   = (state_q == ST_LR3);
                end
            end
        end
    end

    // Sticky error: first cause is kept; a new error in the same cycle as clr_err wins.
    always_comb begin
        err_d      = err;
        err_code_d = err_code_q;
        if (err_set) begin
            err_d = 1'b1;
            if (!err || clr_err) begin
                err_code_d = err_cause;
            end
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    // State, pulse and error registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            left_done  <= 1'b0;
            right_done <= 1'b0;
            haz_done   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            left_done  <= left_d;
            right_done <= right_d;
            haz_done   <= haz_d;
            busy       <= (state_d != ST_IDLE);
            err        <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err_code = err_code_q;

`ifdef TBIRD_DEC_COUNT_EN
    logic [CNT_W-1:0] left_cnt_q, right_cnt_q, haz_cnt_q;

    // Completed-sequence counters; they step with the pulse and wrap naturally.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
            haz_cnt_q   <= '0;
        end else begin
            left_cnt_q  <= left_cnt_q  + CNT_W'(left_d);
            right_cnt_q <= right_cnt_q + CNT_W'(right_d);
            haz_cnt_q   <= haz_cnt_q   + CNT_W'(haz_d);
        end
    end

    assign left_cnt  = left_cnt_q;
    assign right_cnt = right_cnt_q;
    assign haz_cnt   = haz_cnt_q;
`else
    assign left_cnt  = '0;
    assign right_cnt = '0;
    assign haz_cnt   = '0;
`endif

endmodule
